// File: rtl/sysid_read_arbiter.sv
// Round-robin arbiter sharing one system-ID slave (ID / build timestamp) among
// several requesters, with one read outstanding at a time.
module sysid_read_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int READ_LATENCY = 0,
  parameter int DATA_W       = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic [NUM_REQ-1:0]  req_address,
  output logic [NUM_REQ-1:0]  req_ready,
  output logic [NUM_REQ-1:0]  rsp_valid,
  output logic [DATA_W-1:0]   rsp_readdata,
  output logic                busy,
  output logic                slv_address,
  output logic                slv_read,
  input  logic [DATA_W-1:0]   slv_readdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [1:0]       CNT_INIT = 2'(READ_LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [1:0]       cnt_r;
  logic [1:0]       cnt_s;
  logic [IDX_W-1:0] last_grant_r;
  logic [IDX_W-1:0] winner_r;
  logic             addr_r;
  logic [IDX_W-1:0] pick_s;
  logic [IDX_W-1:0] cand_s;
  logic             found_s;
  logic             accept_s;
  logic             capture_s;

  // Round-robin search upward from the requester after the last grant.
  always_comb begin
    found_s = 1'b0;
    pick_s  = last_grant_r;
    cand_s  = last_grant_r;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = IDX_W'((int'(last_grant_r) + k) % NUM_REQ);
      if (!found_s && req_valid[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state logic: accept in IDLE, count out the slave latency in XFER.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          accept_s = 1'b1;
          cnt_s    = CNT_INIT;
          state_s  = XFER;
        end else begin
          state_s  = IDLE;
        end
      end
      XFER: begin
        if (cnt_r == 2'd0) begin
          capture_s = 1'b1;
          state_s   = RESP;
        end else begin
          cnt_s     = cnt_r - 2'd1;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode; reset gates the combinational accept path immediately.
  always_comb begin
    req_ready   = {NUM_REQ{1'b0}};
    rsp_valid   = {NUM_REQ{1'b0}};
    slv_read    = (state_r == XFER);
    busy        = !reset && (accept_s || (state_r != IDLE));
    if (state_r == XFER) begin
      slv_address = addr_r;
    end else begin
      slv_address = 1'b0;
    end
    if (accept_s && !reset) begin
      req_ready[pick_s] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
    if (state_r == RESP) begin
      rsp_valid[winner_r] = 1'b1;
    end else begin
      rsp_valid = {NUM_REQ{1'b0}};
    end
  end

  // State, grant bookkeeping and read-data capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= 2'd0;
      last_grant_r <= LAST_IDX;
      winner_r     <= {IDX_W{1'b0}};
      addr_r       <= 1'b0;
      rsp_readdata <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        winner_r     <= pick_s;
        addr_r       <= req_address[pick_s];
        last_grant_r <= pick_s;
      end
      if (capture_s) begin
        rsp_readdata <= slv_readdata;
      end
    end
  end

endmodule
